// File: rtl/vend_pkg.sv
// Shared coin codes, coin values and FSM state encoding for the change dispenser.
package vend_pkg;

  localparam logic [1:0] COIN_10  = 2'd0;
  localparam logic [1:0] COIN_20  = 2'd1;
  localparam logic [1:0] COIN_50  = 2'd2;
  localparam logic [1:0] COIN_100 = 2'd3;

  localparam int unsigned VAL_10  = 10;
  localparam int unsigned VAL_20  = 20;
  localparam int unsigned VAL_50  = 50;
  localparam int unsigned VAL_100 = 100;

  localparam int unsigned VEND_MAX_AMT = 250;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_DONE,
    S_ERR
  } state_e;

  function automatic int unsigned coin_value(input logic [1:0] code);
    case (code)
      COIN_10: return VAL_10;
      COIN_20: return VAL_20;
      COIN_50: return VAL_50;
      default: return VAL_100;
    endcase
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest denomination not above rem whose stock is available.
module coin_select
  import vend_pkg::*;
#(
  parameter int AMT_W = 8
) (
  input  logic [AMT_W-1:0] rem,
  input  logic [3:0]       stock_ok,
  output logic [1:0]       code,
  output logic             found
);

  logic [31:0] rem_w;
  assign rem_w = 32'(rem);

  always_comb begin
    code  = COIN_10;
    found = 1'b0;
    // Scan upward so the last eligible (largest) coin wins.
    for (int i = 0; i < 4; i++) begin
      if (stock_ok[i] && rem_w >= coin_value(2'(i))) begin
        code  = 2'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Pays out a change amount one coin per hopper handshake, greedy 100/50/20/10.
// Optional per-denomination stock tracking is enabled by defining CHANGE_STOCK_EN.
module change_dispenser
  import vend_pkg::*;
#(
  parameter int AMT_W      = 8,
  parameter int STOCK_W    = 6,
  parameter int STOCK_INIT = 20
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [AMT_W-1:0] change_in,
  input  logic             coin_ack,
  input  logic             refill,
  output logic             coin_valid,
  output logic [1:0]       coin_code,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [4:0]       coin_count
);

  state_e           state;
  logic [AMT_W-1:0] rem;
  logic [AMT_W-1:0] rem_next;
  logic [3:0]       stock_ok;
  logic [1:0]       sel_code;
  logic             sel_found;

  coin_select #(.AMT_W(AMT_W)) u_sel (
    .rem      (rem),
    .stock_ok (stock_ok),
    .code     (sel_code),
    .found    (sel_found)
  );

  // SELECT only picks coins no larger than rem, so this cannot underflow.
  assign rem_next = rem - AMT_W'(coin_value(coin_code));

`ifdef CHANGE_STOCK_EN
  logic [3:0][STOCK_W-1:0] stock;

  always_comb begin
    stock_ok = '0;
    for (int i = 0; i < 4; i++) stock_ok[i] = (stock[i] != '0);
  end

  // Refill takes priority over a coincident ack.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stock <= {4{STOCK_W'(STOCK_INIT)}};
    end else if (refill) begin
      stock <= {4{STOCK_W'(STOCK_INIT)}};
    end else if (state == S_ISSUE && coin_ack) begin
      stock[coin_code] <= stock[coin_code] - STOCK_W'(1);
    end
  end
`else
  logic unused_cfg;
  assign stock_ok   = 4'hF;
  assign unused_cfg = ^{refill, 32'(STOCK_W), 32'(STOCK_INIT)};
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      rem        <= '0;
      coin_valid <= 1'b0;
      coin_code  <= COIN_10;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      coin_count <= '0;
    end else begin
      done  <= 1'b0;
      error <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            coin_count <= '0;
            if ((change_in % AMT_W'(10)) != '0) begin
              error <= 1'b1;
              state <= S_ERR;
            end else if (change_in == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              rem   <= change_in;
              state <= S_SELECT;
            end
          end
        end
        S_SELECT: begin
          if (sel_found) begin
            coin_code  <= sel_code;
            coin_valid <= 1'b1;
            state      <= S_ISSUE;
          end else begin
            error <= 1'b1;
            state <= S_ERR;
          end
        end
        S_ISSUE: begin
          if (coin_ack) begin
            coin_valid <= 1'b0;
            rem        <= rem_next;
            coin_count <= coin_count + 5'd1;
            if (rem_next == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              state <= S_SELECT;
            end
          end
        end
        S_DONE: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        S_ERR: begin
          busy  <= 1'b0;
          rem   <= '0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
